// File: rtl/ps2kbd.sv
// PS/2 keyboard receiver: filtered clock sampling, 11-bit frame deframing, byte FIFO and CPU register window.
// Optional frame watchdog is enabled by defining PS2KBD_TIMEOUT_EN.
module ps2kbd #(
   parameter int FIFO_AW        = 3,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] AD,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   input  logic       rw,
   input  logic       cs,
   output logic       irq,
   input  logic       ps2clk,
   input  logic       ps2dat
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic           clk_s1, clk_s2, dat_s1, dat_s2;
   logic           filt_clk;
   logic [FCW-1:0] filt_cnt;
   logic           strobe;

   state_t         state, state_next;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift;
   logic           par_bit;
   logic           frame_done;
   logic           timeout_hit;

   logic [7:0]     mem [0:(1 << FIFO_AW) - 1];
   logic [FIFO_AW:0] wr_ptr, rd_ptr, count;
   logic           full, avail;
   logic           par_ok, push, pop, flush, wr_en, stat_wr;
   logic           set_perr, set_ferr, set_ovr;
   logic           perr, ferr, ovr, rxie, errie, irqp;
   logic           unused_di;

   // Lines idle high, so synchronisers and the filter come out of reset at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_s1 <= ps2clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2dat;
         dat_s2 <= dat_s1;
         if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign strobe = filt_clk & ~clk_s2 & (filt_cnt == FCW'(FILTER_LEN - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      frame_done = 1'b0;
      case (state)
         IDLE:    if (strobe && !dat_s2) state_next = DATA;
         DATA:    if (strobe && bit_cnt == 3'd7) state_next = PARITY;
         PARITY:  if (strobe) state_next = STOP;
         STOP: begin
            if (strobe) begin
               state_next = IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (timeout_hit) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
      end else if (strobe) begin
         case (state)
            IDLE:    bit_cnt <= '0;
            DATA: begin
               shift   <= {dat_s2, shift[7:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY:  par_bit <= dat_s2;
            default: ;
         endcase
      end
   end

`ifdef PS2KBD_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCW-1:0] wdog;

   // Reloads on every strobe, so only a stalled frame can expire.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE || strobe) wdog <= '0;
      else                                wdog <= wdog + 1'b1;
   end

   assign timeout_hit = (state != IDLE) && !strobe && (wdog == TCW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timeout_hit    = 1'b0;
`endif

   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == FULL_COUNT);
   assign avail    = (count != '0);
   assign par_ok   = ^{shift, par_bit};
   assign set_perr = frame_done & ~par_ok;
   assign set_ferr = (frame_done & par_ok & ~dat_s2) | timeout_hit;
   assign set_ovr  = frame_done & par_ok & dat_s2 & full;
   assign push     = frame_done & par_ok & dat_s2 & ~full;

   assign wr_en    = cs & ~rw;
   assign pop      = cs & rw & (AD == 2'd0) & avail;
   assign flush    = wr_en & (AD == 2'd2) & DI[7];
   assign stat_wr  = wr_en & (AD == 2'd1);
   assign unused_di = ^DI[6:4];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (flush)    rd_ptr <= wr_ptr;
         else if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= shift;
   end

   // A new error in the same cycle as a software clear stays set.
   always_ff @(posedge clk) begin
      if (rst) begin
         perr  <= 1'b0;
         ferr  <= 1'b0;
         ovr   <= 1'b0;
         rxie  <= 1'b0;
         errie <= 1'b0;
      end else begin
         ovr  <= set_ovr  | (ovr  & ~(stat_wr & DI[1]));
         perr <= set_perr | (perr & ~(stat_wr & DI[2]));
         ferr <= set_ferr | (ferr & ~(stat_wr & DI[3]));
         if (wr_en && AD == 2'd2) begin
            rxie  <= DI[0];
            errie <= DI[1];
         end
      end
   end

   assign irqp = (rxie & avail) | (errie & (perr | ovr | ferr));
   assign irq  = irqp;

   always_comb begin
      DO = 8'h00;
      case (AD)
         2'd0:    DO = avail ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;
         2'd1:    DO = {irqp, 3'b000, ferr, perr, ovr, avail};
         2'd2:    DO = {6'b000000, errie, rxie};
         default: DO = {{(7 - FIFO_AW){1'b0}}, count};
      endcase
   end

endmodule

// File: tb/tb_ps2kbd.sv
// Self-checking bench for ps2kbd: directed scenarios with literal expectations, then randomized
// frames and bus traffic checked every cycle against a queue-based model.
module tb_ps2kbd;

   localparam int HALF           = 10;
   localparam int TIMEOUT_CYCLES = 250;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic [1:0] AD     = 2'd3;
   logic [7:0] DI     = 8'h00;
   logic [7:0] DO;
   logic       rw     = 1'b1;
   logic       cs     = 1'b0;
   logic       irq;
   logic       ps2clk = 1'b1;
   logic       ps2dat = 1'b1;

   ps2kbd #(.FIFO_AW(3), .FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
      .irq(irq), .ps2clk(ps2clk), .ps2dat(ps2dat)
   );

   always #5 clk = ~clk;

   // Behavioural model: received bytes in a queue, sticky flags, control bits.
   logic [7:0] q[$];
   bit m_perr, m_ferr, m_ovr, m_rxie, m_errie;
   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   function automatic bit m_irq();
      return (m_rxie && q.size() != 0) || (m_errie && (m_perr || m_ovr || m_ferr));
   endfunction

   function automatic logic [7:0] m_reg(input logic [1:0] a);
      logic [7:0] r;
      bit av;
      av = (q.size() != 0);
      case (a)
         2'd0:    r = av ? q[0] : 8'h00;
         2'd1:    r = {m_irq(), 3'b000, m_ferr, m_perr, m_ovr, av};
         2'd2:    r = {6'b000000, m_errie, m_rxie};
         default: r = 8'(q.size());
      endcase
      return r;
   endfunction

   function automatic void m_reset();
      q.delete();
      m_perr = 0; m_ferr = 0; m_ovr = 0; m_rxie = 0; m_errie = 0;
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("irq", {7'b0, irq}, {7'b0, m_irq()});
         checkOutput($sformatf("reg%0d", AD), DO, m_reg(AD));
      end
   end

   task automatic peek(input logic [1:0] a, input string name, input logic [7:0] exp);
      @(posedge clk); #1 AD = a;
      #1 checkOutput(name, DO, exp);
   endtask

   task automatic peek_irq(input string name, input bit exp);
      @(posedge clk); #2 checkOutput(name, {7'b0, irq}, {7'b0, exp});
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(posedge clk); #1 cs = 1; rw = 0; AD = a; DI = d;
      @(posedge clk); #1 cs = 0; rw = 1;
      if (a == 2'd1) begin
         if (d[1]) m_ovr  = 0;
         if (d[2]) m_perr = 0;
         if (d[3]) m_ferr = 0;
      end else if (a == 2'd2) begin
         if (d[7]) q.delete();
         m_rxie  = d[0];
         m_errie = d[1];
      end
   endtask

   task automatic bus_read(input logic [1:0] a, input bit do_check, input logic [7:0] exp, input string name);
      @(posedge clk); #1 cs = 1; rw = 1; AD = a;
      @(negedge clk);
      if (do_check) checkOutput(name, DO, exp);
      @(posedge clk); #1 cs = 0;
      if (a == 2'd0 && q.size() != 0) void'(q.pop_front());
   endtask

   // err: 0 good, 1 bad parity, 2 bad stop bit. nbits < 11 leaves a partial frame.
   task automatic send_frame(input logic [7:0] b, input int err, input int nbits, input bit read_at_stop);
      logic [10:0] bits;
      logic par;
      bit popped, was_full;
      popped = 0;
      par = ~^b;
      if (err == 1) par = ~par;
      bits = {(err == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk); #1 ps2dat = bits[i];
         repeat (HALF) @(posedge clk);
         #1 ps2clk = 0;
         if (i == 10) begin
            check_en = 0;
            if (read_at_stop) begin
               repeat (5) @(posedge clk);
               #1 cs = 1; rw = 1; AD = 2'd0;
               @(negedge clk) checkOutput("read at stop", DO, m_reg(2'd0));
               @(posedge clk); #1 cs = 0;
               popped = 1;
            end
         end
         repeat ((i == 10 && read_at_stop) ? HALF - 6 : HALF) @(posedge clk);
         #1 ps2clk = 1;
      end
      ps2dat = 1;
      if (nbits == 11) begin
         repeat (8) @(posedge clk);
         #1;
         was_full = (q.size() == 8);
         if (popped && q.size() != 0) void'(q.pop_front());
         if (err == 1)      m_perr = 1;
         else if (err == 2) m_ferr = 1;
         else if (was_full) m_ovr  = 1;
         else               q.push_back(b);
         check_en = 1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1; check_en = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      m_reset();
      check_en = 1;
   endtask

   task automatic applyStimulus(input int n);
      int r, e;
      logic [7:0] d;
      for (int k = 0; k < n; k++) begin
         r = $urandom_range(0, 99);
         if (r < 45) begin
            e = $urandom_range(0, 9);
            d = 8'($urandom);
            send_frame(d, (e == 0) ? 1 : (e == 1) ? 2 : 0, 11, 0);
         end else if (r < 70) begin
            bus_read(2'd0, 0, 8'h00, "");
         end else if (r < 80) begin
            bus_read(2'($urandom_range(1, 3)), 0, 8'h00, "");
         end else if (r < 90) begin
            e = $urandom_range(0, 2);
            bus_write((e == 0) ? 2'd0 : (e == 1) ? 2'd1 : 2'd3, 8'($urandom));
         end else begin
            d = {($urandom_range(0, 7) == 0), 5'b00000, 2'($urandom)};
            bus_write(2'd2, d);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      m_reset();
      repeat (4) @(posedge clk);
      #1 rst = 0;
      peek(2'd1, "reset stat", 8'h00);
      peek(2'd2, "reset ctrl", 8'h00);
      peek(2'd3, "reset cnt", 8'h00);
      peek(2'd0, "reset data", 8'h00);
      peek_irq("reset irq", 1'b0);
      check_en = 1;

      bus_write(2'd2, 8'h01);
      send_frame(8'h1C, 0, 11, 0);
      peek(2'd1, "t1 stat", 8'h81);
      peek(2'd3, "t1 cnt", 8'h01);
      peek_irq("t1 irq", 1'b1);
      bus_read(2'd0, 1, 8'h1C, "t1 data");
      peek(2'd3, "t1 cnt after read", 8'h00);
      peek_irq("t1 irq after read", 1'b0);

      bus_write(2'd2, 8'h02);
      send_frame(8'h1C, 1, 11, 0);
      peek(2'd1, "t2 stat", 8'h84);
      peek(2'd3, "t2 cnt", 8'h00);
      peek_irq("t2 irq", 1'b1);
      bus_write(2'd1, 8'h04);
      peek(2'd1, "t2 stat cleared", 8'h00);
      peek_irq("t2 irq cleared", 1'b0);

      bus_write(2'd2, 8'h03);
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11, 0);
      peek(2'd3, "t3 cnt", 8'h08);
      peek(2'd1, "t3 stat", 8'h83);
      for (int i = 1; i <= 8; i++) bus_read(2'd0, 1, 8'(i), $sformatf("t3 data%0d", i));
      peek(2'd3, "t3 cnt empty", 8'h00);
      peek(2'd0, "t3 data empty", 8'h00);
      bus_write(2'd1, 8'h02);
      peek(2'd1, "t3 stat cleared", 8'h00);

      send_frame(8'h33, 0, 11, 0);
      send_frame(8'h44, 0, 11, 1);
      peek(2'd3, "t4 cnt", 8'h01);
      peek(2'd0, "t4 head", 8'h44);
      bus_read(2'd0, 1, 8'h44, "t4 data");

      for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 0, 11, 0);
      peek(2'd3, "t5 cnt", 8'h05);
      bus_write(2'd2, 8'h80);
      peek(2'd3, "t5 cnt flushed", 8'h00);
      peek(2'd1, "t5 stat flushed", 8'h00);
      peek(2'd2, "t5 ctrl", 8'h00);
      bus_write(2'd2, 8'h03);
      send_frame(8'h5A, 0, 5, 0);
      do_reset();
      peek(2'd1, "t5 stat after rst", 8'h00);
      peek(2'd2, "t5 ctrl after rst", 8'h00);
      peek(2'd3, "t5 cnt after rst", 8'h00);
      send_frame(8'h5A, 0, 11, 0);
      peek(2'd0, "t5 data", 8'h5A);
      peek(2'd3, "t5 cnt new", 8'h01);
      bus_read(2'd0, 1, 8'h5A, "t5 read");

      @(posedge clk); #1 ps2clk = 0;
      repeat (2) @(posedge clk);
      #1 ps2clk = 1;
      repeat (10) @(posedge clk);
      send_frame(8'h6B, 0, 11, 0);
      peek(2'd0, "glitch data", 8'h6B);
      bus_read(2'd0, 1, 8'h6B, "glitch read");

`ifdef PS2KBD_TIMEOUT_EN
      send_frame(8'h29, 0, 3, 0);
      check_en = 0;
      repeat (TIMEOUT_CYCLES + 20) @(posedge clk);
      #1 m_ferr = 1;
      check_en = 1;
      peek(2'd1, "t6 stat", 8'h08);
      bus_write(2'd1, 8'h08);
      send_frame(8'h29, 0, 11, 0);
      peek(2'd0, "t6 data", 8'h29);
      peek(2'd1, "t6 stat", 8'h01);
      bus_read(2'd0, 1, 8'h29, "t6 read");
`endif

      applyStimulus(120);

      repeat (4) @(posedge clk);
      check_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
